// File: rtl/asym_fifo_pkg.sv
// Shared constants and helpers for the asymmetric FIFO controller.
// Holds the default geometry, the derived units-per-access constants, the
// fill-level width helper and a configuration sanity check used at
// elaboration time.
package asym_fifo_pkg;

  localparam int DEF_RAM_DEPTH = 32;
  localparam int DEF_WR_WIDTH  = 8;
  localparam int DEF_RD_WIDTH  = 32;
  localparam int DEF_RAM_WIDTH = 8;

  // RAM units moved by one producer write / one consumer read
  localparam int DEF_WR_IND = DEF_WR_WIDTH / DEF_RAM_WIDTH;
  localparam int DEF_RD_IND = DEF_RD_WIDTH / DEF_RAM_WIDTH;

  // Level must represent 0..depth inclusive, hence one bit more than the address
  function automatic int lvl_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Depth power of two, widths integral multiples of the RAM unit, and
  // depth divisible by both granule sizes so no granule straddles the wrap.
  function automatic bit cfg_ok(input int depth, input int ram_w,
                                input int wr_w, input int rd_w);
    bit ok;
    ok = (depth > 0) && ((depth & (depth - 1)) == 0);
    ok = ok && (ram_w > 0) && (wr_w % ram_w == 0) && (rd_w % ram_w == 0);
    ok = ok && (wr_w >= ram_w) && (rd_w >= ram_w);
    if (ok) begin
      ok = (depth % (wr_w / ram_w) == 0) && (depth % (rd_w / ram_w) == 0);
    end
    return ok;
  endfunction

endpackage

// File: rtl/asym_fifo_ctrl_if.sv
// Producer/consumer bus of the asymmetric FIFO controller.
//   master: the user side (drives wr_req/wr_data/rd_req, sees flags and data)
//   slave : the controller side
// Signals: wr_req, wr_data, full, almost_full, wr_overflow,
//          rd_req, rd_data, rd_valid, empty, almost_empty, rd_underflow,
//          fill_level.
interface asym_fifo_ctrl_if import asym_fifo_pkg::*; #(
  parameter int WR_WIDTH = DEF_WR_WIDTH,
  parameter int RD_WIDTH = DEF_RD_WIDTH,
  parameter int LVL_W    = lvl_width(DEF_RAM_DEPTH)
);
  logic                wr_req;
  logic [WR_WIDTH-1:0] wr_data;
  logic                full;
  logic                almost_full;
  logic                wr_overflow;
  logic                rd_req;
  logic [RD_WIDTH-1:0] rd_data;
  logic                rd_valid;
  logic                empty;
  logic                almost_empty;
  logic                rd_underflow;
  logic [LVL_W-1:0]    fill_level;

  modport master (
    output wr_req, wr_data, rd_req,
    input  full, almost_full, wr_overflow, rd_data, rd_valid,
           empty, almost_empty, rd_underflow, fill_level
  );

  modport slave (
    input  wr_req, wr_data, rd_req,
    output full, almost_full, wr_overflow, rd_data, rd_valid,
           empty, almost_empty, rd_underflow, fill_level
  );
endinterface

// File: rtl/asym_fifo_ptr.sv
// Granule pointer: advances by STEP (mod 2**W) on each cycle inc is high.
// Ports: clk, rst (sync, active-high, clears to 0), inc, ptr (registered).
module asym_fifo_ptr #(
  parameter int STEP = 1,
  parameter int W    = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  // Natural W-bit overflow implements the modulo-depth wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + W'(STEP);
    end
  end

endmodule

// File: rtl/asym_fifo_ctrl.sv
// Single-clock controller running an asymmetric simple dual-port RAM as a
// synchronous FIFO: narrow producer writes, wide consumer reads.
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   bus (slave)     : producer/consumer handshake, flags, fill level, read data
//   ram_wr_en/addr/data : RAM write port
//   ram_rd_addr     : RAM read address (always driven with the read pointer)
//   ram_rd_data     : RAM registered read data, passed straight to bus.rd_data
module asym_fifo_ctrl import asym_fifo_pkg::*; #(
  parameter int RAM_DEPTH      = DEF_RAM_DEPTH,
  parameter int RAM_ADDR_WIDTH = $clog2(RAM_DEPTH),
  parameter int WR_WIDTH       = DEF_WR_WIDTH,
  parameter int RD_WIDTH       = DEF_RD_WIDTH,
  parameter int RAM_WIDTH      = DEF_RAM_WIDTH,
  parameter int WR_IND         = WR_WIDTH / RAM_WIDTH,
  parameter int RD_IND         = RD_WIDTH / RAM_WIDTH,
  parameter int AF_LEVEL       = 28,
  parameter int AE_LEVEL       = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  asym_fifo_ctrl_if.slave           bus,
  output logic                      ram_wr_en,
  output logic [RAM_ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [WR_WIDTH-1:0]       ram_wr_data,
  output logic [RAM_ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [RD_WIDTH-1:0]       ram_rd_data
);

  localparam int LVL_W = RAM_ADDR_WIDTH + 1;

  if (!cfg_ok(RAM_DEPTH, RAM_WIDTH, WR_WIDTH, RD_WIDTH)) begin : g_bad_geometry
    $error("asym_fifo_ctrl: inconsistent depth/width configuration");
  end
  if (RAM_ADDR_WIDTH != $clog2(RAM_DEPTH) ||
      WR_IND != WR_WIDTH / RAM_WIDTH || RD_IND != RD_WIDTH / RAM_WIDTH) begin : g_bad_derived
    $error("asym_fifo_ctrl: derived parameters do not match widths");
  end

  logic [RAM_ADDR_WIDTH-1:0] wr_ptr;
  logic [RAM_ADDR_WIDTH-1:0] rd_ptr;
  logic [LVL_W-1:0]          level;
  logic [LVL_W-1:0]          level_next;
  logic                      full_q;
  logic                      empty_q;
  logic                      af_q;
  logic                      ae_q;
  logic                      ovf_q;
  logic                      unf_q;
  logic                      vld_p1;
  logic                      wr_acc;
  logic                      rd_acc;

  // Both requests are judged on the registered flags, so a simultaneous
  // write and read can each be accepted in the same cycle.
  assign wr_acc = bus.wr_req & ~full_q;
  assign rd_acc = bus.rd_req & ~empty_q;

  asym_fifo_ptr #(.STEP(WR_IND), .W(RAM_ADDR_WIDTH)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (wr_acc),
    .ptr (wr_ptr)
  );

  asym_fifo_ptr #(.STEP(RD_IND), .W(RAM_ADDR_WIDTH)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (rd_acc),
    .ptr (rd_ptr)
  );

  // Flow control keeps level within 0..RAM_DEPTH, so no saturation needed
  always_comb begin
    level_next = level;
    if (wr_acc) level_next = level_next + LVL_W'(WR_IND);
    if (rd_acc) level_next = level_next - LVL_W'(RD_IND);
  end

  // ---- stage p1: level, flags, sticky errors and read-data qualifier ----
  always_ff @(posedge clk) begin
    if (rst) begin
      level   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      level   <= level_next;
      full_q  <= level_next >  LVL_W'(RAM_DEPTH - WR_IND);
      empty_q <= level_next <  LVL_W'(RD_IND);
      af_q    <= level_next >= LVL_W'(AF_LEVEL);
      ae_q    <= level_next <= LVL_W'(AE_LEVEL);
      ovf_q   <= ovf_q | (bus.wr_req & full_q);
      unf_q   <= unf_q | (bus.rd_req & empty_q);
      vld_p1  <= rd_acc;
    end
  end

  assign ram_wr_en   = wr_acc;
  assign ram_wr_addr = wr_ptr;
  assign ram_wr_data = bus.wr_data;
  assign ram_rd_addr = rd_ptr;

  assign bus.rd_data      = ram_rd_data;
  assign bus.rd_valid     = vld_p1;
  assign bus.full         = full_q;
  assign bus.almost_full  = af_q;
  assign bus.wr_overflow  = ovf_q;
  assign bus.empty        = empty_q;
  assign bus.almost_empty = ae_q;
  assign bus.rd_underflow = unf_q;
  assign bus.fill_level   = level;

endmodule

// File: tb/tb_asym_fifo_ctrl.sv
// Directed self-checking bench for asym_fifo_ctrl with a behavioural
// 32 x 8 -> 8 x 32 RAM (registered read, lowest address in the MSBs).
module tb_asym_fifo_ctrl;
  import asym_fifo_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ram_wr_en;
  logic [4:0]  ram_wr_addr;
  logic [7:0]  ram_wr_data;
  logic [4:0]  ram_rd_addr;
  logic [31:0] ram_rd_data = '0;
  logic [7:0]  mem [32];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  asym_fifo_ctrl_if #(.WR_WIDTH(8), .RD_WIDTH(32), .LVL_W(6)) bus ();

  asym_fifo_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_data (ram_wr_data),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data)
  );

  // Behavioural RAM: write and registered read on the same clock
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    ram_rd_data <= {mem[ram_rd_addr], mem[ram_rd_addr + 5'd1],
                    mem[ram_rd_addr + 5'd2], mem[ram_rd_addr + 5'd3]};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wr1(input logic [7:0] d);
    bus.wr_req  = 1'b1;
    bus.wr_data = d;
    step();
    bus.wr_req  = 1'b0;
  endtask

  function automatic logic [31:0] word_of(input int k);
    return {8'(4 * k), 8'(4 * k + 1), 8'(4 * k + 2), 8'(4 * k + 3)};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sent;
    int got;
    int cyc;
    logic wa;

    bus.wr_req  = 1'b0;
    bus.wr_data = '0;
    bus.rd_req  = 1'b0;

    // Reset state
    do_reset();
    chk("rst_empty",  bus.empty,        1);
    chk("rst_aempty", bus.almost_empty, 1);
    chk("rst_full",   bus.full,         0);
    chk("rst_afull",  bus.almost_full,  0);
    chk("rst_valid",  bus.rd_valid,     0);
    chk("rst_ovf",    bus.wr_overflow,  0);
    chk("rst_unf",    bus.rd_underflow, 0);
    chk("rst_level",  bus.fill_level,   0);
    chk("rst_wraddr", ram_wr_addr,      0);
    chk("rst_rdaddr", ram_rd_addr,      0);

    // Fill one word and read it back
    wr1(8'h11);
    chk("f1_level", bus.fill_level, 1);
    wr1(8'h22);
    wr1(8'h33);
    chk("f3_empty", bus.empty, 1);
    wr1(8'h44);
    chk("f4_empty", bus.empty, 0);
    chk("f4_level", bus.fill_level, 4);
    chk("f4_aempty", bus.almost_empty, 1);
    bus.rd_req = 1'b1;
    step();
    bus.rd_req = 1'b0;
    chk("r1_valid", bus.rd_valid, 1);
    chk("r1_data",  bus.rd_data, 32'h11223344);
    chk("r1_empty", bus.empty, 1);
    chk("r1_level", bus.fill_level, 0);
    step();
    chk("r1_valid_drop", bus.rd_valid, 0);

    // Full boundary
    do_reset();
    for (int k = 1; k <= 32; k++) begin
      wr1(8'(k - 1));
      if (k == 27) chk("full_af27", bus.almost_full, 0);
      if (k == 28) chk("full_af28", bus.almost_full, 1);
      if (k == 31) chk("full_f31",  bus.full, 0);
    end
    chk("full_f32",     bus.full, 1);
    chk("full_level32", bus.fill_level, 32);
    bus.wr_req  = 1'b1;
    bus.wr_data = 8'hEE;
    #1;
    chk("full_wren_blocked", ram_wr_en, 0);
    step();
    bus.wr_req = 1'b0;
    chk("full_wraddr", ram_wr_addr, 0);
    chk("full_ovf",    bus.wr_overflow, 1);
    chk("full_level",  bus.fill_level, 32);
    bus.rd_req = 1'b1;
    for (int j = 0; j < 8; j++) begin
      step();
      chk("drain_valid", bus.rd_valid, 1);
      chk("drain_data",  bus.rd_data, word_of(j));
    end
    bus.rd_req = 1'b0;
    chk("drain_empty",   bus.empty, 1);
    chk("drain_level",   bus.fill_level, 0);
    chk("drain_ovf_stk", bus.wr_overflow, 1);
    chk("drain_unf",     bus.rd_underflow, 0);

    // Empty boundary, then simultaneous write and read
    do_reset();
    wr1(8'hA0);
    wr1(8'hA1);
    wr1(8'hA2);
    bus.rd_req = 1'b1;
    step();
    bus.rd_req = 1'b0;
    chk("emp_valid",  bus.rd_valid, 0);
    chk("emp_rdaddr", ram_rd_addr, 0);
    chk("emp_unf",    bus.rd_underflow, 1);
    chk("emp_level",  bus.fill_level, 3);
    wr1(8'hA3);
    chk("emp_level4", bus.fill_level, 4);
    chk("emp_clear",  bus.empty, 0);
    bus.wr_req  = 1'b1;
    bus.wr_data = 8'hB0;
    bus.rd_req  = 1'b1;
    step();
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    chk("sim_level",  bus.fill_level, 1);
    chk("sim_empty",  bus.empty, 1);
    chk("sim_valid",  bus.rd_valid, 1);
    chk("sim_data",   bus.rd_data, 32'hA0A1A2A3);
    chk("sim_wraddr", ram_wr_addr, 5);
    chk("sim_rdaddr", ram_rd_addr, 4);
    chk("sim_unf_stk", bus.rd_underflow, 1);

    // Wrap: 200 bytes streamed, consumer paced randomly
    do_reset();
    sent = 0;
    got  = 0;
    cyc  = 0;
    while (got < 50 && cyc < 4000) begin
      bus.wr_req  = (sent < 200) && !bus.full;
      bus.wr_data = 8'(sent);
      bus.rd_req  = !bus.empty && ($urandom_range(0, 1) == 1);
      #1;
      wa = ram_wr_en;
      @(posedge clk);
      #1;
      if (wa) sent++;
      if (bus.rd_valid) begin
        chk("wrap_word", bus.rd_data, word_of(got));
        got++;
      end
      cyc++;
    end
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    chk("wrap_count",  got, 50);
    chk("wrap_ovf",    bus.wr_overflow, 0);
    chk("wrap_unf",    bus.rd_underflow, 0);
    chk("wrap_level",  bus.fill_level, 0);
    chk("wrap_wraddr", ram_wr_addr, 8);
    chk("wrap_rdaddr", ram_rd_addr, 8);

    // Reset in the middle of operation, with a read request pending
    do_reset();
    for (int k = 0; k < 20; k++) wr1(8'(k + 8'h60));
    chk("mid_level20", bus.fill_level, 20);
    rst = 1'b1;
    bus.rd_req = 1'b1;
    step();
    rst = 1'b0;
    bus.rd_req = 1'b0;
    chk("mid_level", bus.fill_level, 0);
    chk("mid_empty", bus.empty, 1);
    chk("mid_valid", bus.rd_valid, 0);
    chk("mid_afull", bus.almost_full, 0);
    bus.wr_req  = 1'b1;
    bus.wr_data = 8'h5A;
    #1;
    chk("mid_wraddr", ram_wr_addr, 0);
    chk("mid_wren",   ram_wr_en, 1);
    step();
    bus.wr_req = 1'b0;
    chk("mid_level1", bus.fill_level, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/asym_fifo_ctrl.md
Name: asym_fifo_ctrl

Overview:
- Single-clock controller that sequences the asymmetric simple dual-port RAM as a synchronous FIFO.
- Owns the write and read pointers, the fill level in RAM_WIDTH units, the full/empty/almost flags and the sticky overflow/underflow errors.
- Drives the RAM write and read address ports. Both RAM clocks are tied to clk in the wrapper.
- Sits between a narrow producer (WR_WIDTH) and a wide consumer (RD_WIDTH).

Parameters:
- RAM_DEPTH, 32: RAM units; power of 2; multiple of WR_IND and RD_IND.
- RAM_ADDR_WIDTH, 5: log2(RAM_DEPTH).
- WR_WIDTH, 8: producer data width.
- RD_WIDTH, 32: consumer data width.
- RAM_WIDTH, 8: RAM unit width.
- WR_IND, 1: WR_WIDTH/RAM_WIDTH, units consumed per write.
- RD_IND, 4: RD_WIDTH/RAM_WIDTH, units consumed per read.
- AF_LEVEL, 28: almost_full threshold, in units.
- AE_LEVEL, 4: almost_empty threshold, in units.

Ports:
- clk, in, 1: single clock; feeds the RAM wr_clk and rd_clk.
- rst, in, 1: synchronous, active-high reset.
- wr_req, in, 1: producer write request.
- wr_data, in, WR_WIDTH: producer data.
- full, out, 1: no room for one write granule.
- almost_full, out, 1: level >= AF_LEVEL.
- wr_overflow, out, 1: sticky; wr_req seen while full.
- rd_req, in, 1: consumer read request.
- rd_data, out, RD_WIDTH: read data; valid only while rd_valid = 1.
- rd_valid, out, 1: rd_data qualifier.
- empty, out, 1: less than one read granule stored.
- almost_empty, out, 1: level <= AE_LEVEL.
- rd_underflow, out, 1: sticky; rd_req seen while empty.
- fill_level, out, RAM_ADDR_WIDTH+1: stored units, 0..RAM_DEPTH.
- ram_wr_en, out, 1: to RAM wr_en.
- ram_wr_addr, out, RAM_ADDR_WIDTH: to RAM wr_addr.
- ram_wr_data, out, WR_WIDTH: to RAM wr_data.
- ram_rd_addr, out, RAM_ADDR_WIDTH: to RAM rd_addr.
- ram_rd_data, in, RD_WIDTH: from RAM rd_data.

Behaviour:
- Reset: wr_ptr = 0, rd_ptr = 0, level = 0.
  - Outputs on reset: empty = 1, almost_empty = 1, full = 0, almost_full = 0, rd_valid = 0, wr_overflow = 0, rd_underflow = 0.
  - RAM contents are not cleared.
  - Reset mid-operation discards all stored data. An in-flight rd_valid for the next cycle is suppressed.
- Write accept: wr_acc = wr_req & ~full.
  - ram_wr_en = wr_acc (combinational).
  - ram_wr_addr = wr_ptr; ram_wr_data = wr_data.
  - On wr_acc: wr_ptr += WR_IND, mod RAM_DEPTH.
- Read accept: rd_acc = rd_req & ~empty.
  - ram_rd_addr = rd_ptr (always driven).
  - On rd_acc: rd_ptr += RD_IND, mod RAM_DEPTH.
  - rd_valid is registered: rd_valid = rd_acc of the previous cycle.
  - rd_data = ram_rd_data, combinational passthrough. Latency is 1 cycle from rd_acc to rd_valid.
  - The RAM output changes every cycle, so the consumer must sample rd_data only when rd_valid = 1.
- Pointers start at 0 and advance in whole granules. Because RAM_DEPTH is a multiple of both IND values, no granule straddles the wrap.
- Level update: level_next = level + (wr_acc ? WR_IND : 0) - (rd_acc ? RD_IND : 0). Width is RAM_ADDR_WIDTH+1; no saturation is needed.
- Flags are registered from level_next:
  - full = level_next > RAM_DEPTH - WR_IND
  - empty = level_next < RD_IND
  - almost_full = level_next >= AF_LEVEL
  - almost_empty = level_next <= AE_LEVEL
- Simultaneous wr_req and rd_req: both are judged on the current flags and both may be accepted in the same cycle.
- A write accepted at edge t is readable from cycle t+1. Data written at edge t is in the RAM before a read issued at t+1 samples it, so there is no bypass.
- Rejected requests: ignored, with no pointer or level change.
  - wr_req & full sets wr_overflow.
  - rd_req & empty sets rd_underflow.
  - Both flags stay set until rst.
- Byte order is the RAM's: the lowest-address unit maps to the MSBs of rd_data.

Decomposition:
- Shared package asym_fifo_pkg holds:
  - the derived constants WR_IND and RD_IND;
  - a level-width function (clog2(depth)+1);
  - elaboration checks: depth a power of 2, WIDTH ratios integral, depth divisible by each IND.
- Sub-module asym_fifo_ptr, instantiated twice (write and read):
  - parameterised step and width;
  - inc input, registered pointer output, synchronous reset.
- The wrapper asym_fifo_sync instantiates asym_fifo_ctrl plus the existing RAM.

Test Plan:
- Fill and read: write 0x11, 0x22, 0x33, 0x44 on consecutive cycles. Required: empty drops the cycle after the 4th write. Then rd_req for one cycle gives rd_valid = 1 the next cycle with rd_data = 0x11223344, then empty = 1 and fill_level = 0.
- Full boundary: 32 writes give full = 1 and fill_level = 32, with almost_full asserted after the 28th write. A 33rd wr_req leaves ram_wr_en = 0, wr_ptr unchanged and wr_overflow = 1.
- Empty boundary: with level = 3, rd_req must give rd_valid = 0 next cycle, rd_ptr unchanged and rd_underflow = 1. A following write brings level to 4 and clears empty.
- Simultaneous: with level = 4, wr_req and rd_req in the same cycle must give fill_level = 1, empty = 1, and rd_valid next cycle with the oldest 4 bytes.
- Wrap: stream 200 incrementing bytes with random rd_req pacing. All 50 words must arrive in order with no overflow or underflow flags.
- Reset mid-op: level = 20, assert rst for 1 cycle. Required: fill_level = 0, empty = 1, rd_valid = 0 the next cycle, and the next write lands at address 0.
